// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-controller states, halt code and queue entry type
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [7:0] HALT_CODE_DEFAULT = 8'hFF;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - two-entry instruction queue with push, pop and flush
module fetch_queue
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  qentry_t    push_data,
    input  logic       pop,
    input  logic       flush,
    output qentry_t    head_data,
    output logic       head_valid,
    output logic [1:0] count
);

    qentry_t    r_mem [0:1];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop & (r_count != 2'd0);
    assign w_do_push = push & ((r_count != 2'd2) | w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_valid = (r_count != 2'd0);
    assign head_data  = head_valid ? r_mem[r_rd_ptr] : '0;
    assign count      = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch controller feeding a two-entry decode queue
module imem_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int         MEM_DEPTH = 36,
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] HALT_CODE = HALT_CODE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_pc,
    output logic       instr_valid,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    input  logic       instr_ready,
    output logic       busy,
    output logic       halted,
    output logic       addr_err
);

    localparam logic [8:0] LP_DEPTH = 9'(MEM_DEPTH);

    fetch_state_t r_state;
    logic [7:0]   r_fetch_pc;
    logic         r_addr_err;

    logic       w_active;
    logic       w_flush;
    logic       w_pop;
    logic       w_push;
    logic       w_in_range;
    logic       w_is_halt;
    logic       w_can_push;
    logic       w_head_valid;
    logic [1:0] w_count;
    qentry_t    w_push_entry;
    qentry_t    w_head_entry;

    assign w_active     = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign w_flush      = w_active & redirect_valid;
    assign w_pop        = w_active & w_head_valid & instr_ready;
    assign w_in_range   = ({1'b0, r_fetch_pc} < LP_DEPTH);
    assign w_is_halt    = (imem_data == HALT_CODE);
    assign w_can_push   = (w_count != 2'd2) | w_pop;
    assign w_push       = (r_state == ST_RUN) & ~redirect_valid & w_in_range
                          & ~w_is_halt & w_can_push;
    assign w_push_entry = '{pc: r_fetch_pc, instr: imem_data};

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_data  (w_push_entry),
        .pop        (w_pop),
        .flush      (w_flush),
        .head_data  (w_head_entry),
        .head_valid (w_head_valid),
        .count      (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr_err <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_fetch_pc <= RESET_PC;
                    end
                end
                ST_RUN: begin
                    // Redirect outranks everything, including the range and halt checks.
                    if (redirect_valid) begin
                        r_fetch_pc <= redirect_pc;
                    end else if (!w_in_range) begin
                        r_addr_err <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end else if (w_is_halt) begin
                        r_state <= ST_DRAIN;
                    end else if (w_push) begin
                        r_fetch_pc <= r_fetch_pc + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_valid) begin
                        r_state    <= ST_RUN;
                        r_fetch_pc <= redirect_pc;
                    end else if ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop)) begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_fetch_pc <= RESET_PC;
                        r_addr_err <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = w_head_valid;
    assign instr       = w_head_entry.instr;
    assign instr_pc    = w_head_entry.pc;
    assign busy        = w_active;
    assign halted      = (r_state == ST_HALTED);
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       busy;
    logic       halted;
    logic       addr_err;

    logic [7:0] mem [0:255];
    int n_tests;
    int n_fail;
    int idx;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .busy           (busy),
        .halted         (halted),
        .addr_err       (addr_err)
    );

    always_comb imem_data = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},     imem_addr,   8'h00);
        chk({tag, "_valid"},    instr_valid, 1'b0);
        chk({tag, "_instr"},    instr,       8'h00);
        chk({tag, "_ipc"},      instr_pc,    8'h00);
        chk({tag, "_busy"},     busy,        1'b0);
        chk({tag, "_halted"},   halted,      1'b0);
        chk({tag, "_addr_err"}, addr_err,    1'b0);
    endtask

    task automatic wait_halted(input string tag);
        for (int c = 0; c < 20 && !halted; c++) tick();
        chk(tag, halted, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hFF;
        mem[8'h10] = 8'h5A; mem[8'h11] = 8'h6B; mem[8'h12] = 8'hFF;

        #2 reset = 1'b1;
        #1 chk_reset_vals("rst");
        tick();
        tick();
        reset = 1'b0;

        // Basic program with decode always ready.
        instr_ready = 1'b1;
        pulse_start();
        chk("run_busy", busy, 1'b1);
        chk("run_addr0", imem_addr, 8'h00);
        chk("run_empty", instr_valid, 1'b0);
        tick();
        chk("seq1_instr", instr, 8'h11);
        chk("seq1_pc", instr_pc, 8'h00);
        chk("seq1_valid", instr_valid, 1'b1);
        tick();
        chk("seq2_instr", instr, 8'h22);
        chk("seq2_pc", instr_pc, 8'h01);
        tick();
        chk("seq3_instr", instr, 8'h33);
        chk("seq3_pc", instr_pc, 8'h02);
        tick();
        chk("seq_drain_valid", instr_valid, 1'b0);
        wait_halted("seq_halted");
        chk("seq_addr_err", addr_err, 1'b0);
        chk("seq_busy_off", busy, 1'b0);

        // Back-pressure: queue fills, fetch stalls, nothing lost.
        instr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        chk("bp_addr_hold", imem_addr, 8'h02);
        chk("bp_head_instr", instr, 8'h11);
        chk("bp_head_pc", instr_pc, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_start_ignored", imem_addr, 8'h02);
        instr_ready = 1'b1;
        tick();
        chk("bp_2_instr", instr, 8'h22);
        chk("bp_2_pc", instr_pc, 8'h01);
        tick();
        chk("bp_3_instr", instr, 8'h33);
        chk("bp_3_pc", instr_pc, 8'h02);
        tick();
        chk("bp_halted", halted, 1'b1);
        chk("bp_empty", instr_valid, 1'b0);

        // Redirect with a full queue.
        instr_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        chk("rd_full_addr", imem_addr, 8'h02);
        redirect_valid = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect_valid = 1'b0;
        chk("rd_flush_valid", instr_valid, 1'b0);
        chk("rd_new_addr", imem_addr, 8'h10);
        tick();
        chk("rd_head_pc", instr_pc, 8'h10);
        chk("rd_head_instr", instr, 8'h5A);
        instr_ready = 1'b1;
        tick();
        chk("rd_next_pc", instr_pc, 8'h11);
        chk("rd_next_instr", instr, 8'h6B);
        wait_halted("rd_halted");
        redirect_valid = 1'b1;
        redirect_pc = 8'h05;
        tick();
        redirect_valid = 1'b0;
        chk("rd_ignored_halted", halted, 1'b1);
        chk("rd_ignored_addr", imem_addr, 8'h12);

        // Run off the end of memory: all 36 entries then addr_err.
        for (int i = 0; i < 36; i++) mem[i] = 8'(i + 8'h40);
        idx = 0;
        pulse_start();
        for (int c = 0; c < 200 && !halted; c++) begin
            tick();
            if (instr_valid) begin
                chk("end_pc", instr_pc, 8'(idx));
                chk("end_instr", instr, 8'(idx + 8'h40));
                idx++;
            end
        end
        chk("end_count", idx, 36);
        chk("end_halted", halted, 1'b1);
        chk("end_addr_err", addr_err, 1'b1);
        pulse_start();
        chk("restart_addr_err", addr_err, 1'b0);
        chk("restart_addr", imem_addr, 8'h00);
        tick();
        chk("restart_pc", instr_pc, 8'h00);
        chk("restart_instr", instr, 8'h40);

        // Asynchronous reset mid-run with a full queue.
        instr_ready = 1'b0;
        tick();
        tick();
        chk("ar_full_addr", imem_addr, 8'h02);
        #3 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_addr", imem_addr, 8'h00);
        chk("idle_valid", instr_valid, 1'b0);
        pulse_start();
        tick();
        chk("post_rst_pc", instr_pc, 8'h00);
        chk("post_rst_instr", instr, 8'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
